ascon_perm_ctrl: RTL and testbench
==================================

// Module: ascon_perm_ctrl
// PURPOSE
//  Round sequencer driving permutation_step1 (initiator side of its round/enable/select interface).
//  - Runs p^a (12 rounds) or p^b (6 rounds) on request and drives round index, enable and input select.
//  - Signals completion, so the Ascon-128 top FSM only issues start and waits for done.
//  - Sits between the top-level AEAD controller and the permutation datapath; holds no state data.
// PARAMETERS
//  NB_ROUNDS_A  12  rounds for p^a (init/finalisation); round indices 12-NB_ROUNDS_A .. 11
//  NB_ROUNDS_B  6   rounds for p^b (data processing); round indices 12-NB_ROUNDS_B .. 11
// PORTS
//  clock_i       in   1  single clock, rising edge
//  reset_i       in   1  asynchronous, active-high reset
//  start_i       in   1  request a permutation run; sampled in IDLE or DONE only
//  mode_i        in   1  0 = p^a (NB_ROUNDS_A), 1 = p^b (NB_ROUNDS_B); sampled with start_i
//  abort_i       in   1  cancel current run (present only with ASCON_PERM_ABORT_EN)
//  round_o       out  4  round index to permutation_step1.round_i
//  enable_o      out  1  to permutation_step1.enable_i; state register updates when high
//  selectionp_o  out  1  to permutation_step1.selectionp_i; 0 = external state in, 1 = feedback
//  busy_o        out  1  high while rounds are being applied (state RUN)
//  done_o        out  1  one-cycle pulse; permutation_o holds final state in this cycle
// BEHAVIOUR
//  - States: IDLE, RUN, DONE; 4-bit round counter rnd_q and 4-bit first-round register first_q.
//  - Reset (async, reset_i=1): state=IDLE, rnd_q=0, first_q=0; outputs round_o=0, enable_o=0,
//    selectionp_o=0, busy_o=0, done_o=0. Reset mid-run discards the run; no done_o is produced.
//  - IDLE: all outputs at reset values. start_i=1 -> RUN, rnd_q=first_q=(mode_i ? 12-NB_ROUNDS_B : 12-NB_ROUNDS_A).
//  - RUN: enable_o=1, busy_o=1, round_o=rnd_q; selectionp_o=0 when rnd_q==first_q, else 1.
//    rnd_q increments every cycle; rnd_q==11 -> DONE next edge. start_i/mode_i ignored in RUN.
//  - DONE: done_o=1 for exactly one cycle, enable_o=0, busy_o=0, round_o=11 held, selectionp_o=1.
//    start_i=1 in DONE -> RUN directly (back-to-back, no IDLE gap); else -> IDLE.
//  - Latency: start accepted at edge t -> N RUN cycles (N=12 or 6) -> done_o high in cycle t+N+1.
//  - Outputs are decoded from registered state and counter only (no input-to-output comb path).
//  - round_o never exceeds 11; counter never wraps; illegal state encodings recover to IDLE.
//  - Parameters restricted to 1..12; values outside are a synthesis-time error ($error in elaboration).
// CONFIGURATION
//  ASCON_PERM_ABORT_EN defined: abort_i port present; abort_i=1 in RUN or DONE -> IDLE next edge,
//    enable_o drops in the following cycle, no done_o pulse; abort_i has priority over start_i in DONE.
//    abort_i in IDLE has no effect.
//  ASCON_PERM_ABORT_EN undefined: no abort_i port; runs always complete to DONE.
// TESTING
//  1. reset_i=1 then 0, start_i=0 for 5 cycles -> all outputs 0, state IDLE.
//  2. start_i=1,mode_i=0 for 1 cycle, state_in=80400c0600000000/0001020304050607/08090a0b0c0d0e0f/
//     0011223344556677/8899aabbccddeeff -> round_o 0..11 in 12 cycles, selectionp_o 0 then 1,
//     done_o 1 in cycle 13; permutation_o matches golden-model p^12 of that state.
//  3. start_i=1,mode_i=1 -> round_o 6..11, selectionp_o=0 only at round 6, done_o in cycle 7.
//  4. start_i pulsed at round 4 of a p^a run -> ignored; still exactly one done_o after round 11.
//  5. start_i=1,mode_i=1 during done_o cycle -> next cycle round_o=6, selectionp_o=0, no IDLE cycle.
//  6. reset_i=1 asynchronously at round 7 -> outputs 0 immediately, no done_o;
//     with ASCON_PERM_ABORT_EN, abort_i at round 7 -> IDLE next edge, no done_o.

Source files
------------

// File: rtl/ascon_perm_ctrl.sv
// Round sequencer for the Ascon permutation datapath: runs p^a or p^b, drives round/enable/select.
// Optional abort input enabled by defining ASCON_PERM_ABORT_EN.
module ascon_perm_ctrl #(
    parameter int NB_ROUNDS_A = 12,
    parameter int NB_ROUNDS_B = 6
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       mode_i,
`ifdef ASCON_PERM_ABORT_EN
    input  logic       abort_i,
`endif
    output logic [3:0] round_o,
    output logic       enable_o,
    output logic       selectionp_o,
    output logic       busy_o,
    output logic       done_o
);

    generate
        if (NB_ROUNDS_A < 1 || NB_ROUNDS_A > 12) begin : g_bad_rounds_a
            $error("ascon_perm_ctrl: NB_ROUNDS_A must be within 1..12");
        end
        if (NB_ROUNDS_B < 1 || NB_ROUNDS_B > 12) begin : g_bad_rounds_b
            $error("ascon_perm_ctrl: NB_ROUNDS_B must be within 1..12");
        end
    endgenerate

    localparam logic [3:0] FIRST_A  = 4'(12 - NB_ROUNDS_A);
    localparam logic [3:0] FIRST_B  = 4'(12 - NB_ROUNDS_B);
    localparam logic [3:0] LAST_RND = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q;
    logic [3:0] rnd_q;
    logic [3:0] first_q;
    logic [3:0] first_sel;
    logic [3:0] rnd_next;
    logic       abort_w;

`ifdef ASCON_PERM_ABORT_EN
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    // Starting round index for the requested permutation; only feeds registers.
    assign first_sel = mode_i ? FIRST_B : FIRST_A;
    assign rnd_next  = rnd_q + 4'd1;

    // Outputs are registered alongside the state, so each output reflects the state entered at the edge.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            rnd_q        <= 4'd0;
            first_q      <= 4'd0;
            round_o      <= 4'd0;
            enable_o     <= 1'b0;
            selectionp_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q      <= RUN;
                        rnd_q        <= first_sel;
                        first_q      <= first_sel;
                        round_o      <= first_sel;
                        enable_o     <= 1'b1;
                        selectionp_o <= 1'b0;
                        busy_o       <= 1'b1;
                        done_o       <= 1'b0;
                    end else begin
                        state_q      <= IDLE;
                        rnd_q        <= 4'd0;
                        first_q      <= 4'd0;
                        round_o      <= 4'd0;
                        enable_o     <= 1'b0;
                        selectionp_o <= 1'b0;
                        busy_o       <= 1'b0;
                        done_o       <= 1'b0;
                    end
                end

                RUN: begin
                    if (abort_w) begin
                        state_q      <= IDLE;
                        rnd_q        <= 4'd0;
                        first_q      <= 4'd0;
                        round_o      <= 4'd0;
                        enable_o     <= 1'b0;
                        selectionp_o <= 1'b0;
                        busy_o       <= 1'b0;
                        done_o       <= 1'b0;
                    end else if (rnd_q >= LAST_RND) begin
                        // Final round applied; hold round 11 and feedback select while done pulses.
                        state_q      <= DONE;
                        rnd_q        <= LAST_RND;
                        round_o      <= LAST_RND;
                        enable_o     <= 1'b0;
                        selectionp_o <= 1'b1;
                        busy_o       <= 1'b0;
                        done_o       <= 1'b1;
                    end else begin
                        state_q      <= RUN;
                        rnd_q        <= rnd_next;
                        round_o      <= rnd_next;
                        enable_o     <= 1'b1;
                        selectionp_o <= (rnd_next != first_q);
                        busy_o       <= 1'b1;
                        done_o       <= 1'b0;
                    end
                end

                DONE: begin
                    if (!abort_w && start_i) begin
                        // Back-to-back request: go straight into the next run.
                        state_q      <= RUN;
                        rnd_q        <= first_sel;
                        first_q      <= first_sel;
                        round_o      <= first_sel;
                        enable_o     <= 1'b1;
                        selectionp_o <= 1'b0;
                        busy_o       <= 1'b1;
                        done_o       <= 1'b0;
                    end else begin
                        state_q      <= IDLE;
                        rnd_q        <= 4'd0;
                        first_q      <= 4'd0;
                        round_o      <= 4'd0;
                        enable_o     <= 1'b0;
                        selectionp_o <= 1'b0;
                        busy_o       <= 1'b0;
                        done_o       <= 1'b0;
                    end
                end

                default: begin
                    state_q      <= IDLE;
                    rnd_q        <= 4'd0;
                    first_q      <= 4'd0;
                    round_o      <= 4'd0;
                    enable_o     <= 1'b0;
                    selectionp_o <= 1'b0;
                    busy_o       <= 1'b0;
                    done_o       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Scoreboard bench for ascon_perm_ctrl: stimulus queues expected per-cycle outputs, monitor compares.
module tb_ascon_perm_ctrl;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic       mode_i;
    logic [3:0] round_o;
    logic       enable_o;
    logic       selectionp_o;
    logic       busy_o;
    logic       done_o;
`ifdef ASCON_PERM_ABORT_EN
    logic       abort_i;
`endif

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  rnd;
        logic        selp;
        logic        en;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    ascon_perm_ctrl #(.NB_ROUNDS_A(12), .NB_ROUNDS_B(6)) dut (
        .clock_i      (clk),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .mode_i       (mode_i),
`ifdef ASCON_PERM_ABORT_EN
        .abort_i      (abort_i),
`endif
        .round_o      (round_o),
        .enable_o     (enable_o),
        .selectionp_o (selectionp_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: any non-idle output cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_i && (enable_o || done_o || busy_o || selectionp_o || round_o != 4'd0)) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output cyc=%0d round=%0d en=%0b selp=%0b busy=%0b done=%0b (required idle)",
                         cyc, round_o, enable_o, selectionp_o, busy_o, done_o);
            end else begin
                e = sb.pop_front();
                if (e.cyc != 32'(cyc) || e.rnd != round_o || e.selp != selectionp_o ||
                    e.en != enable_o || e.busy != busy_o || e.done != done_o) begin
                    n_fail++;
                    $display("FAIL run_cycle got cyc=%0d round=%0d en=%0b selp=%0b busy=%0b done=%0b, required cyc=%0d round=%0d en=%0b selp=%0b busy=%0b done=%0b",
                             cyc, round_o, enable_o, selectionp_o, busy_o, done_o,
                             e.cyc, e.rnd, e.en, e.selp, e.busy, e.done);
                end
            end
        end
    end

    task automatic check_idle(input string name);
        n_chk++;
        if ({round_o, enable_o, selectionp_o, busy_o, done_o} != 8'd0) begin
            n_fail++;
            $display("FAIL %s got round=%0d en=%0b selp=%0b busy=%0b done=%0b, required all 0",
                     name, round_o, enable_o, selectionp_o, busy_o, done_o);
        end
    endtask

    task automatic check_int(input string name, input int got, input int req);
        n_chk++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    // Called at a negedge: request a run accepted at the next edge and queue its expected trace.
    task automatic issue(input logic m, output int k);
        int   n;
        int   first;
        exp_t e;
        start_i = 1'b1;
        mode_i  = m;
        k       = cyc + 1;
        n       = m ? 6 : 12;
        first   = 12 - n;
        for (int i = 0; i < n; i++) begin
            e.cyc  = 32'(k + i);
            e.rnd  = 4'(first + i);
            e.selp = (i != 0);
            e.en   = 1'b1;
            e.busy = 1'b1;
            e.done = 1'b0;
            sb.push_back(e);
        end
        e.cyc  = 32'(k + n);
        e.rnd  = 4'd11;
        e.selp = 1'b1;
        e.en   = 1'b0;
        e.busy = 1'b0;
        e.done = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start_i = 1'b0;
        mode_i  = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int k2;
        reset_i = 1'b1;
        start_i = 1'b0;
        mode_i  = 1'b0;
`ifdef ASCON_PERM_ABORT_EN
        abort_i = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        reset_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_idle("idle_after_reset");
        end

        // p^a: rounds 0..11 then done
        issue(1'b0, k);
        wait_cyc(k + 14);
        check_idle("idle_after_pa");

        // p^b: rounds 6..11 then done
        issue(1'b1, k);
        wait_cyc(k + 8);
        check_idle("idle_after_pb");

        // start pulsed at round 4 of p^a is ignored
        issue(1'b0, k);
        wait_cyc(k + 4);
        start_i = 1'b1;
        mode_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        mode_i  = 1'b0;
        wait_cyc(k + 16);
        check_idle("idle_after_ignored_start");

        // back-to-back: new p^b requested during the done cycle
        issue(1'b0, k);
        wait_cyc(k + 12);
        issue(1'b1, k2);
        check_int("b2b_accept_edge", k2, k + 13);
        wait_cyc(k2 + 8);
        check_idle("idle_after_b2b");

        // asynchronous reset at round 7 of p^a
        issue(1'b0, k);
        wait_cyc(k + 7);
        @(posedge clk);
        #2 reset_i = 1'b1;
        #1 check_idle("async_reset_mid_run");
        check_int("reset_discards_rest", sb.size(), 5);
        sb.delete();
        @(negedge clk);
        reset_i = 1'b0;
        repeat (16) @(negedge clk);
        check_idle("idle_after_reset_run");

`ifdef ASCON_PERM_ABORT_EN
        // abort at round 7 of p^a
        issue(1'b0, k);
        wait_cyc(k + 7);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check_idle("abort_mid_run");
        check_int("abort_discards_rest", sb.size(), 5);
        sb.delete();
        repeat (16) @(negedge clk);
        check_idle("idle_after_abort");
`endif

        // p^b again after everything, plus final drain
        issue(1'b1, k);
        wait_cyc(k + 10);
        check_idle("idle_final");
        check_int("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
